minmax_window_sched: RTL and testbench
======================================

// Module: minmax_window_sched
// PURPOSE
//  Windowed min/max scheduler: accepts a stream of unsigned samples over valid/ready,
//  tracks running minimum and maximum, and at window end emits one result record.
//  The tracker is cleared to min=all-ones/max=0 at each window start.
//  Sits between a sample producer and the result consumer of the min/max datapath.
// PARAMETERS
//  W    4  sample width in bits (unsigned)
//  WIN  8  samples per window, >=2; CW = $clog2(WIN+1) is the count width
// PORTS
//  clock      in   1   single clock, rising edge
//  reset_n    in   1   asynchronous, active-low reset
//  enable     in   1   permits a new window to open
//  flush      in   1   pulse: close the current partial window early
//  in_valid   in   1   sample valid
//  in_ready   out  1   sample accepted when in_valid & in_ready
//  in_data    in   W   sample value
//  out_valid  out  1   result record valid
//  out_ready  in   1   consumer accepts the record when out_valid & out_ready
//  out_min    out  W   window minimum
//  out_max    out  W   window maximum
//  out_count  out  CW  samples in the emitted window, 1..WIN
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; min_r={W{1}}; max_r=0; cnt=0; in_ready=0; out_valid=0; busy=0;
//   out_min/out_max/out_count=0. Reset asserted mid-window drops partial data, no emit.
//  FSM:
//   IDLE : in_ready=0. enable=1 -> ACCUM on next edge. enable=0 -> stay.
//   ACCUM: in_ready=1. On accept: min_r<=min(min_r,in_data), max_r<=max(max_r,in_data),
//          cnt<=cnt+1. First sample of a window gives min=max=sample.
//          Accept with cnt==WIN-1 -> EMIT; result includes that sample.
//          flush=1 with cnt>0 -> EMIT; a sample accepted in the same cycle is included.
//          flush=1 with cnt==0 and no accept: ignored, stay in ACCUM.
//          enable is ignored in ACCUM; a window opened always completes or is flushed.
//   EMIT : in_ready=0. out_valid=1. out_min/out_max/out_count are registered on entry
//          and held stable until the handshake. flush is ignored.
//          On out_ready=1: min_r<={W{1}}, max_r<=0, cnt<=0, out_valid<=0;
//          next state is ACCUM if enable=1, else IDLE.
//  Latency: the last accepted sample at edge N gives out_valid=1 after edge N, i.e.
//   one registered cycle. Back-to-back windows lose exactly one input cycle per window
//   (EMIT); with out_ready held at 1, EMIT lasts one cycle.
//  Compares are unsigned. Equal values leave min/max unchanged. cnt never exceeds WIN.
//  in_data is don't-care when in_valid=0. Outputs outside EMIT keep their last values.
// CONFIGURATION
//  MINMAX_RANGE_EN defined: extra port out_range (out, W) = out_max - out_min.
//   The value is registered with the record and valid with out_valid.
//   It is never negative because max >= min for any count >= 1.
//  Undefined: no out_range port and no subtractor; all other behaviour is identical.
// TESTING
//  1 Reset: reset_n=0 asynchronously mid-ACCUM -> in_ready=0, busy=0, out_valid=0 at once.
//  2 Full window, W=4, WIN=8: samples 5,3,9,7,3,12,6,8 with out_ready=1 ->
//    out_min=3, out_max=12, out_count=8, out_valid for 1 cycle; range=9 when
//    MINMAX_RANGE_EN is defined.
//  3 Flush: 4,15 then flush -> min=4, max=15, count=2. A second flush while cnt==0 -> no emit.
//  4 Backpressure: out_ready=0 for 5 cycles in EMIT -> in_ready=0 and outputs stable.
//    Then out_ready=1 -> next window starts with all-ones/0 (single sample 0 -> min=max=0).
//  5 enable=0 during EMIT handshake -> IDLE, busy=0, in_ready=0.
//    Then enable=1 -> ACCUM after 1 cycle.
//  6 Flush in the same cycle as the 8th accept -> a single emit with out_count=8.

Source files
------------

// File: rtl/minmax_window_sched.sv
// Windowed min/max scheduler: collects up to WIN unsigned samples, then presents one
// min/max/count record over valid/ready. Define MINMAX_RANGE_EN to add the out_range port.
module minmax_window_sched #(
    parameter int W   = 4,
    parameter int WIN = 8,
    parameter int CW  = $clog2(WIN + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_min,
    output logic [W-1:0]  out_max,
    output logic [CW-1:0] out_count,
`ifdef MINMAX_RANGE_EN
    output logic [W-1:0]  out_range,
`endif
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [W-1:0]   min_r;
    logic [W-1:0]   max_r;
    logic [CW-1:0]  cnt;

    logic           accept;
    logic           close_win;
    logic           release_rec;
    logic [W-1:0]   min_nxt;
    logic [W-1:0]   max_nxt;
    logic [CW-1:0]  cnt_nxt;

    // Tracker update including the sample accepted this cycle, so a closing window
    // (last sample or flush) can capture its final result in the same edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        min_nxt = min_r;
        max_nxt = max_r;
        cnt_nxt = cnt;
        accept  = in_valid && in_ready;
        if (accept) begin
            if (in_data < min_r) min_nxt = in_data;
            if (in_data > max_r) max_nxt = in_data;
            cnt_nxt = cnt + CW'(1);
        end
        close_win   = (state == ACCUM) &&
                      ((accept && (cnt == CW'(WIN - 1))) || (flush && (cnt_nxt != '0)));
        release_rec = (state == EMIT) && out_ready;
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process ordering.
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; enable only matters when no window is open.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (enable)      state_nxt = ACCUM;
            ACCUM:   if (close_win)   state_nxt = EMIT;
            EMIT:    if (release_rec) state_nxt = enable ? ACCUM : IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Output decode: handshake flags follow the state directly, so reset clears them at once.
    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == EMIT);
        busy      = (state != IDLE);
    end

    // Running tracker; cleared when the record is taken so the next window starts fresh.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            min_r <= '1;
            max_r <= '0;
            cnt   <= '0;
        end else if (release_rec) begin
            min_r <= '1;
            max_r <= '0;
            cnt   <= '0;
        end else if (state == ACCUM) begin
            min_r <= min_nxt;
            max_r <= max_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Result record, loaded on the closing edge and held until the consumer takes it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_min   <= '0;
            out_max   <= '0;
            out_count <= '0;
        end else if (close_win) begin
            out_min   <= min_nxt;
            out_max   <= max_nxt;
            out_count <= cnt_nxt;
        end
    end

`ifdef MINMAX_RANGE_EN
    // max >= min whenever at least one sample was taken, so this never wraps.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)       out_range <= '0;
        else if (close_win) out_range <= max_nxt - min_nxt;
    end
`endif

endmodule

// File: tb/tb_minmax_window_sched.sv
// Self-checking bench for minmax_window_sched: directed scenarios plus random traffic,
// scored against a queue-based window model.
module tb_minmax_window_sched;

    localparam int W   = 4;
    localparam int WIN = 8;
    localparam int CW  = $clog2(WIN + 1);

    logic          clock;
    logic          reset_n;
    logic          enable;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_min;
    logic [W-1:0]  out_max;
    logic [CW-1:0] out_count;
`ifdef MINMAX_RANGE_EN
    logic [W-1:0]  out_range;
`endif
    logic          busy;

    minmax_window_sched #(.W(W), .WIN(WIN)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_min   (out_min),
        .out_max   (out_max),
        .out_count (out_count),
`ifdef MINMAX_RANGE_EN
        .out_range (out_range),
`endif
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef enum {M_IDLE, M_ACCUM, M_EMIT} mode_t;
    typedef struct {
        int mn;
        int mx;
        int cnt;
    } rec_t;

    mode_t      m_mode;
    int         win_q[$];
    rec_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Close the collected window: the record is the plain min/max/size of its samples.
    task automatic push_record();
        rec_t r;
        r.mn  = win_q[0];
        r.mx  = win_q[0];
        r.cnt = win_q.size();
        foreach (win_q[i]) begin
            if (win_q[i] < r.mn) r.mn = win_q[i];
            if (win_q[i] > r.mx) r.mx = win_q[i];
        end
        sb.push_back(r);
        win_q.delete();
    endtask

    // Predict the effect of the coming clock edge given the inputs now driven.
    task automatic model_next();
        case (m_mode)
            M_IDLE:  if (enable) m_mode = M_ACCUM;
            M_ACCUM: begin
                if (in_valid) win_q.push_back(int'(in_data));
                if (win_q.size() == WIN || (flush && win_q.size() > 0)) begin
                    push_record();
                    m_mode = M_EMIT;
                end
            end
            M_EMIT:  if (out_ready) m_mode = enable ? M_ACCUM : M_IDLE;
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic check_ctrl();
        check("in_ready",  32'(in_ready),  32'(m_mode == M_ACCUM));
        check("out_valid", 32'(out_valid), 32'(m_mode == M_EMIT));
        check("busy",      32'(busy),      32'(m_mode != M_IDLE));
    endtask

    // One clock: check control outputs just after the edge, then drive the next inputs.
    task automatic cycle(input logic en, input logic fl, input logic iv,
                         input logic [W-1:0] id, input logic ordy);
        @(posedge clock);
        #1;
        check_ctrl();
        enable    = en;
        flush     = fl;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        model_next();
    endtask

    // Monitor: inputs and outputs are settled at the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n && out_valid) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_record: got min=%0d max=%0d count=%0d, expected none",
                             out_min, out_max, out_count);
                end else begin
                    check("out_min",   32'(out_min),   32'(sb[0].mn));
                    check("out_max",   32'(out_max),   32'(sb[0].mx));
                    check("out_count", 32'(out_count), 32'(sb[0].cnt));
`ifdef MINMAX_RANGE_EN
                    check("out_range", 32'(out_range), 32'(sb[0].mx - sb[0].mn));
`endif
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    int full_win[8] = '{5, 3, 9, 7, 3, 12, 6, 8};

    initial begin
        m_mode    = M_IDLE;
        reset_n   = 1'b0;
        enable    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_out_min",   32'(out_min),   32'd0);
        check("rst_out_max",   32'(out_max),   32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Full window of eight samples, consumer always ready.
        cycle(1, 0, 0, 0, 1);
        foreach (full_win[i]) cycle(1, 0, 1, W'(full_win[i]), 1);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);

        // Flush of a partial window, then a flush with nothing collected.
        cycle(1, 0, 1, 4'd4, 1);
        cycle(1, 0, 1, 4'd15, 1);
        cycle(1, 1, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 1, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);

        // Backpressure: record held for five cycles while samples are offered.
        cycle(1, 0, 1, 4'd2, 0);
        cycle(1, 0, 1, 4'd11, 0);
        cycle(1, 1, 0, 0, 0);
        repeat (5) cycle(1, 1, 1, 4'd7, 0);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 1, 4'd0, 1);
        cycle(1, 1, 0, 0, 1);

        // enable low during the handshake returns to IDLE; raising it reopens.
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 1, 4'd9, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);

        // Flush coinciding with the eighth accept yields one full record.
        for (int i = 0; i < WIN - 1; i++) cycle(1, 0, 1, W'(i + 3), 1);
        cycle(1, 1, 1, 4'd1, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);

        // Asynchronous reset in the middle of a window drops it.
        cycle(1, 0, 1, 4'd6, 1);
        cycle(1, 0, 1, 4'd13, 1);
        cycle(1, 0, 0, 0, 1);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_in_ready",  32'(in_ready),  32'd0);
        check("midrst_busy",      32'(busy),      32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        enable   = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        win_q.delete();
        m_mode   = M_IDLE;
        @(negedge clock);
        reset_n = 1'b1;
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 1, 4'd8, 1);
        cycle(1, 1, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 9) < 7),
                  W'($urandom_range(0, (1 << W) - 1)),
                  ($urandom_range(0, 9) < 6));
        end

        // Drain any held record.
        repeat (4) cycle(0, 0, 0, 0, 1);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
